// File: rtl/stop_watch_pkg.sv
// Shared state type, BCD limit and digit clamp helper for the parametrised BCD stopwatch.
package stop_watch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/stop_watch_bcd_n_digit.sv
// One BCD digit of the stopwatch counter: up/down step with carry/borrow chaining,
// synchronous clear/preset and a terminal flag (9 when counting up, 0 when counting down).
module bcd_digit
  import stop_watch_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_step,
  input  logic       i_dir,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_cout,
  output logic       o_term
);

  logic [3:0] r_digit;
  logic [3:0] w_next;

  assign o_term  = i_dir ? (r_digit == 4'd0) : (r_digit == BCD_MAX);
  assign o_cout  = i_cin & o_term;
  assign o_digit = r_digit;

  always_comb begin
    w_next = r_digit;
    if (i_dir) begin
      w_next = (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
    end else begin
      w_next = (r_digit >= BCD_MAX) ? 4'd0 : r_digit + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_digit <= 4'd0;
    end else if (i_clear) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_val);
    end else if (i_step && i_cin) begin
      r_digit <= w_next;
    end
  end

endmodule

// File: rtl/stop_watch_bcd_n.sv
// Parametrised BCD stopwatch: prescaler, run/pause/done FSM, priority control and digit chain.
// Optional lap-freeze display path is built when STOP_WATCH_LAP_EN is defined.
module stop_watch_bcd_n
  import stop_watch_pkg::*;
#(
  parameter int DVSR   = 100000,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  zero,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  dir,
  input  logic                  wrap_en,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  tick,
  output logic                  wrap,
  output logic                  done,
  output logic                  lap_active
);

  localparam int PW = $clog2(DVSR);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);

  sw_state_t           r_state;
  sw_state_t           w_state_next;
  logic [PW-1:0]       r_presc;
  logic                r_wrap;
  logic [4*DIGITS-1:0] w_count;
  logic [DIGITS-1:0]   w_cin;
  logic [DIGITS-1:0]   w_cout;
  logic [DIGITS-1:0]   w_term;
  logic                w_tick;
  logic                w_tick_eff;
  logic                w_all_term;
  logic                w_sat;
  logic                w_step;
  logic                w_wrap_evt;

  // zero, load and stop outrank the tick, so a tick coinciding with any of them is dropped
  assign w_tick     = (r_state == RUN) && (r_presc == PRESC_LAST);
  assign w_tick_eff = w_tick & ~(zero | load | stop);
  assign w_all_term = &w_term;
  assign w_sat      = w_tick_eff & w_all_term & ~wrap_en;
  assign w_step     = w_tick_eff & ~w_sat;
  assign w_wrap_evt = w_step & w_cout[DIGITS-1];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign w_cin[gi] = 1'b1;
      end else begin : g_upper
        assign w_cin[gi] = w_cout[gi-1];
      end

      bcd_digit u_digit (
        .clk        (clk),
        .clr        (clr),
        .i_clear    (zero),
        .i_load     (load),
        .i_load_val (load_val[4*gi +: 4]),
        .i_step     (w_step),
        .i_dir      (dir),
        .i_cin      (w_cin[gi]),
        .o_digit    (w_count[4*gi +: 4]),
        .o_cout     (w_cout[gi]),
        .o_term     (w_term[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // stop blocks start even when it has nothing to pause
  always_comb begin
    w_state_next = r_state;
    if (zero || load) begin
      w_state_next = IDLE;
    end else if (stop) begin
      if (r_state == RUN) begin
        w_state_next = PAUSE;
      end
    end else if (start && (r_state == IDLE || r_state == PAUSE)) begin
      w_state_next = RUN;
    end else if (w_sat) begin
      w_state_next = DONE;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_presc <= '0;
    end else if (zero || load) begin
      r_presc <= '0;
    end else if (r_state == RUN && !stop) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_evt;
    end
  end

  assign running = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign tick    = w_tick;
  assign wrap    = r_wrap;

`ifdef STOP_WATCH_LAP_EN
  logic                r_lap_active;
  logic [4*DIGITS-1:0] r_lap;

  // the snapshot is taken only on entry to the freeze; leaving it reveals the live count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_lap_active <= 1'b0;
      r_lap        <= '0;
    end else if (zero || load) begin
      r_lap_active <= 1'b0;
    end else if (lap && (r_state == RUN || r_state == PAUSE)) begin
      if (!r_lap_active) begin
        r_lap <= w_count;
      end
      r_lap_active <= ~r_lap_active;
    end
  end

  assign lap_active = r_lap_active;
  assign digits     = r_lap_active ? r_lap : w_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign lap_active   = 1'b0;
  assign digits       = w_count;
`endif

endmodule

// File: doc/stop_watch_bcd_n.md
# stop_watch_bcd_n

Parametrised BCD stopwatch/timer, successor to the fixed 4-digit stopwatch. Counts a configurable number of decimal digits up or down at a divided tick rate, with start/stop/preset control, saturate-or-wrap terminal handling, and an optional lap-freeze display path. Sits between the button/detector conditioning logic and the seven-segment multiplexer, which consumes the packed BCD output.

## Interface
- DVSR, 100000: clk cycles per count tick (≥2)
- DIGITS, 4: number of BCD digits (1..8)
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse: begin/resume counting
- stop  in  1  single-cycle pulse: pause
- zero  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous preset from load_val
- load_val  in  4*DIGITS  preset value, digit 0 in bits [3:0]
- dir  in  1  0 = count up, 1 = count down
- wrap_en  in  1  1 = wrap at terminal, 0 = saturate and stop
- lap  in  1  single-cycle pulse: toggle display freeze
- digits  out  4*DIGITS  displayed BCD value
- running  out  1  state is RUN
- tick  out  1  count-tick strobe
- wrap  out  1  one-cycle pulse on wrap-around
- done  out  1  high in DONE state
- lap_active  out  1  display frozen

## Operation
- States: IDLE, RUN, PAUSE, DONE. clr forces IDLE, count = 0, prescaler = 0, lap_active = 0, all outputs 0.
- Per-cycle priority: zero > load > stop > start > tick.
- zero: count = 0, prescaler = 0, lap_active = 0, state → IDLE.
- load: count = load_val with any digit >9 clamped to 9, prescaler = 0, state → IDLE.
- stop in RUN → PAUSE; start in IDLE or PAUSE → RUN; start and stop together → stop wins; start in DONE ignored.
- Prescaler 0..DVSR-1, advances only in RUN, held in IDLE/PAUSE/DONE. tick = (prescaler == DVSR-1) && RUN.
- On tick, up: digit 0 increments, 9→0 carries to the next digit. Down: 0→9 borrows.
- Terminal value: all-9s (up), all-0s (down). tick at terminal with wrap_en=1: up → 0, down → all-9s, wrap=1 for that cycle, stay RUN. With wrap_en=0: count unchanged, state → DONE, done=1.
- DONE exits only via zero, load or clr.
- dir and wrap_en sampled only on tick cycles; a change mid-interval takes effect on the next tick.

## Timing
- digits, wrap and state update on the rising edge at the end of the tick cycle. Latency from tick to new digits: 1 clk.
- Controls are registered: start issued in cycle n gives running=1 from cycle n+1. First tick after start from prescaler 0 comes DVSR cycles later.
- clr is asynchronous: outputs go to reset values immediately, with no clock needed. Deassertion is synchronised by the integrator.
- tick, wrap: exactly one cycle wide.

## Configuration
- STOP_WATCH_LAP_EN defined:
  - lap pulse in RUN or PAUSE toggles lap_active.
  - Entering the freeze captures the current count into the lap register. While lap_active=1, digits shows the lap register and the internal count keeps running.
  - zero, load and clr clear lap_active. lap in IDLE or DONE is ignored.
- STOP_WATCH_LAP_EN undefined: lap input ignored, lap_active tied 0, digits always shows the live count, no lap register.

## Structure
- stop_watch_pkg holds:
  - state enum {IDLE, RUN, PAUSE, DONE}
  - BCD_MAX = 4'd9
  - a BCD clamp function
- Sub-module bcd_digit: one 4-bit up/down digit with enable, carry/borrow in and out, and a terminal flag. Instantiated DIGITS times in a generate chain.
- The top level owns the prescaler, FSM, priority logic and lap register.

## Test plan
All scenarios use DVSR=4, DIGITS=2.
- Up count: clr, then start, then 40 cycles → digits=0x10, tick every 4th cycle, running=1.
- Up saturate: load 0x98, wrap_en=0, start, 2 ticks → digits 0x99, then DONE with done=1 and digits held at 0x99. start ignored; zero → 0x00, IDLE.
- Down wrap: load 0x01, dir=1, wrap_en=1, start, 2 ticks → 0x00, then 0x99 with wrap=1 for one cycle, running stays 1.
- Pause/priority:
  - stop mid-interval freezes the prescaler; start resumes and the next tick arrives after the remaining cycles.
  - start+stop in the same cycle → PAUSE.
  - load 0xAF → digits 0x99.
- Async reset: clr asserted mid-RUN between clock edges → digits=0, running=0, done=0 before the next edge.
- Lap (STOP_WATCH_LAP_EN): at 0x05 pulse lap → digits holds 0x05 while the internal count reaches 0x08; lap again → digits=0x08.
